// File: rtl/accumulator_unit_if.sv
// Bus between the control unit and the accumulator execute stage: operation
// request (start/opcode/operands) and the ACC/flag/strobe results.
interface accumulator_unit_if #(
   parameter int word_size   = 8,
   parameter int opcode_size = 4
);
   logic                   start;
   logic [opcode_size-1:0] opcode;
   logic [word_size-1:0]   reg_data;
   logic [word_size-1:0]   imm;
   logic [word_size-1:0]   acc_out;
   logic                   load_reg;
   logic                   busy;
   logic                   done;
   logic                   zero_flag;
   logic                   carry_flag;

   modport master (
      output start, opcode, reg_data, imm,
      input  acc_out, load_reg, busy, done, zero_flag, carry_flag
   );

   modport slave (
      input  start, opcode, reg_data, imm,
      output acc_out, load_reg, busy, done, zero_flag, carry_flag
   );
endinterface

// File: rtl/accumulator_unit.sv
// Accumulator/ALU execute stage: single-cycle ALU ops on ACC and an
// iterative shift-add multiply sequenced by a two-state FSM.
module accumulator_unit #(
   parameter int word_size   = 8,
   parameter int opcode_size = 4
) (
   input logic          clk,
   input logic          rst,
   accumulator_unit_if.slave bus
);
   localparam int cnt_w = $clog2(word_size);
   localparam logic [cnt_w-1:0] LAST_ITER = cnt_w'(word_size - 1);

   localparam logic [opcode_size-1:0] OP_LDR  = opcode_size'(1);
   localparam logic [opcode_size-1:0] OP_LDI  = opcode_size'(2);
   localparam logic [opcode_size-1:0] OP_STR  = opcode_size'(3);
   localparam logic [opcode_size-1:0] OP_ADD  = opcode_size'(4);
   localparam logic [opcode_size-1:0] OP_SUB  = opcode_size'(5);
   localparam logic [opcode_size-1:0] OP_AND  = opcode_size'(6);
   localparam logic [opcode_size-1:0] OP_OR   = opcode_size'(7);
   localparam logic [opcode_size-1:0] OP_XOR  = opcode_size'(8);
   localparam logic [opcode_size-1:0] OP_NOT  = opcode_size'(9);
   localparam logic [opcode_size-1:0] OP_SHL  = opcode_size'(10);
   localparam logic [opcode_size-1:0] OP_SHR  = opcode_size'(11);
   localparam logic [opcode_size-1:0] OP_MUL  = opcode_size'(12);
   localparam logic [opcode_size-1:0] OP_ADDI = opcode_size'(13);

   typedef enum logic {IDLE, MUL} state_t;

   state_t                 state, state_next;
   logic [word_size-1:0]   acc, acc_next;
   logic [word_size-1:0]   mplier, mplier_next;
   logic [2*word_size-1:0] mcand, mcand_next;
   logic [2*word_size-1:0] product, product_next;
   logic [2*word_size-1:0] prod_step;
   logic [cnt_w-1:0]       count, count_next;
   logic                   zero, zero_next;
   logic                   carry, carry_next;
   logic                   done_r, done_next;
   logic                   load_r, load_next;
   logic                   acc_wr;
   logic [word_size:0]     sum_reg, sum_imm, diff;

   assign sum_reg   = {1'b0, acc} + {1'b0, bus.reg_data};
   assign sum_imm   = {1'b0, acc} + {1'b0, bus.imm};
   assign diff      = {1'b0, acc} - {1'b0, bus.reg_data};
   // Multiplier bits are consumed LSB first while the multiplicand shifts up
   assign prod_step = product + (mplier[0] ? mcand : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         mplier  <= '0;
         mcand   <= '0;
         product <= '0;
         count   <= '0;
         zero    <= 1'b0;
         carry   <= 1'b0;
         done_r  <= 1'b0;
         load_r  <= 1'b0;
      end else begin
         state   <= state_next;
         acc     <= acc_next;
         mplier  <= mplier_next;
         mcand   <= mcand_next;
         product <= product_next;
         count   <= count_next;
         zero    <= zero_next;
         carry   <= carry_next;
         done_r  <= done_next;
         load_r  <= load_next;
      end
   end

   always_comb begin
      state_next   = state;
      acc_next     = acc;
      mplier_next  = mplier;
      mcand_next   = mcand;
      product_next = product;
      count_next   = count;
      zero_next    = zero;
      carry_next   = carry;
      done_next    = 1'b0;
      load_next    = 1'b0;
      acc_wr       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.opcode == OP_MUL) begin
                  mcand_next   = {{word_size{1'b0}}, bus.reg_data};
                  mplier_next  = acc;
                  product_next = '0;
                  count_next   = '0;
                  state_next   = MUL;
               end else begin
                  done_next = 1'b1;
                  case (bus.opcode)
                     OP_LDR:  begin acc_next = bus.reg_data; acc_wr = 1'b1; end
                     OP_LDI:  begin acc_next = bus.imm; acc_wr = 1'b1; end
                     OP_STR:  load_next = 1'b1;
                     OP_ADD:  begin {carry_next, acc_next} = sum_reg; acc_wr = 1'b1; end
                     OP_ADDI: begin {carry_next, acc_next} = sum_imm; acc_wr = 1'b1; end
                     OP_SUB:  begin {carry_next, acc_next} = diff; acc_wr = 1'b1; end
                     OP_AND:  begin acc_next = acc & bus.reg_data; carry_next = 1'b0; acc_wr = 1'b1; end
                     OP_OR:   begin acc_next = acc | bus.reg_data; carry_next = 1'b0; acc_wr = 1'b1; end
                     OP_XOR:  begin acc_next = acc ^ bus.reg_data; carry_next = 1'b0; acc_wr = 1'b1; end
                     OP_NOT:  begin acc_next = ~acc; carry_next = 1'b0; acc_wr = 1'b1; end
                     OP_SHL:  begin carry_next = acc[word_size-1]; acc_next = {acc[word_size-2:0], 1'b0}; acc_wr = 1'b1; end
                     OP_SHR:  begin carry_next = acc[0]; acc_next = {1'b0, acc[word_size-1:1]}; acc_wr = 1'b1; end
                     default: ;
                  endcase
                  if (acc_wr) zero_next = (acc_next == '0);
               end
            end
         end
         MUL: begin
            product_next = prod_step;
            mcand_next   = mcand << 1;
            mplier_next  = mplier >> 1;
            count_next   = count + cnt_w'(1);
            if (count == LAST_ITER) begin
               acc_next   = prod_step[word_size-1:0];
               carry_next = |prod_step[2*word_size-1:word_size];
               zero_next  = (prod_step[word_size-1:0] == '0);
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.acc_out    = acc;
   assign bus.zero_flag  = zero;
   assign bus.carry_flag = carry;
   assign bus.done       = done_r;
   assign bus.load_reg   = load_r;
   assign bus.busy       = (state == MUL);
endmodule
